// File: rtl/decim_packer.sv
// Collects RATIO qualified samples into one output word, either packed (first sample in the
// MS slot) or summed, and hands the word to a slower consumer on load.
module decim_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RATIO  = 2,
  parameter int unsigned OUT_W  = DATA_W * RATIO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mode,
  input  logic              load,
  output logic [OUT_W-1:0]  R0,
  output logic              r0_valid,
  output logic              full,
  output logic              overrun
);

  localparam int unsigned SumW = DATA_W + $clog2(RATIO);
  localparam int unsigned CntW = $clog2(RATIO + 1);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic [SumW-1:0]   acc_q, acc_d;
  logic              mode_q, mode_d;
  logic [OUT_W-1:0]  r0_q, r0_d;
  logic              r0_valid_q, r0_valid_d;
  logic              overrun_q, overrun_d;
  logic [OUT_W-1:0]  word_out;

  assign word_out = mode_q ? OUT_W'(acc_q) : word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      mode_q     <= 1'b0;
      r0_q       <= '0;
      r0_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      r0_q       <= r0_d;
      r0_valid_q <= r0_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    r0_d       = r0_q;
    r0_valid_d = 1'b0;
    overrun_d  = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          word_d  = OUT_W'(data_in);
          acc_d   = SumW'(data_in);
          mode_d  = mode;
          cnt_d   = CntW'(1);
          state_d = StFill;
        end
      end
      StFill: begin
        if (en) begin
          // Shift left so the first sample ends up in the MS slot.
          word_d = {word_q[OUT_W-DATA_W-1:0], data_in};
          acc_d  = acc_q + SumW'(data_in);
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(RATIO - 1)) state_d = StFull;
        end
      end
      StFull: begin
        if (load) begin
          r0_d       = word_out;
          r0_valid_d = 1'b1;
          if (en) begin
            word_d  = OUT_W'(data_in);
            acc_d   = SumW'(data_in);
            mode_d  = mode;
            cnt_d   = CntW'(1);
            state_d = StFill;
          end else begin
            word_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else if (en) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    R0       = r0_q;
    r0_valid = r0_valid_q;
    full     = (state_q == StFull);
    overrun  = overrun_q;
  end

endmodule

// File: tb/tb_decim_packer.sv
// Directed scenarios plus a randomized run checked against a sample-list reference model,
// on a RATIO=2 and a RATIO=4 instance sharing the same inputs.
module tb_decim_packer;

  logic        clk = 1'b0;
  logic        rst, en, mode, load;
  logic [7:0]  data_in;
  logic [15:0] r0_2;
  logic        v2, f2, o2;
  logic [31:0] r0_4;
  logic        v4, f4, o4;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: list of held samples per instance (index 0: RATIO=2, 1: RATIO=4).
  logic [7:0]  ms [2][4];
  int          mc [2];
  logic        mm [2];
  logic [31:0] m_r0 [2];
  logic        m_v [2];
  logic        m_ov [2];

  always #5 clk = ~clk;

  decim_packer #(.DATA_W(8), .RATIO(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .mode(mode), .load(load),
    .R0(r0_2), .r0_valid(v2), .full(f2), .overrun(o2)
  );

  decim_packer #(.DATA_W(8), .RATIO(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .mode(mode), .load(load),
    .R0(r0_4), .r0_valid(v4), .full(f4), .overrun(o4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; load = 1'b0; mode = 1'b0; data_in = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic m, input logic ld);
    en = 1'b1; data_in = d; mode = m; load = ld;
    tick();
    idle_inputs();
  endtask

  task automatic m_step(input int k, input int r);
    logic [31:0] w;
    if (rst) begin
      mc[k] = 0; m_r0[k] = '0; m_v[k] = 1'b0; m_ov[k] = 1'b0; mm[k] = 1'b0;
    end else begin
      m_v[k] = 1'b0;
      if (mc[k] == r) begin
        if (load) begin
          w = '0;
          for (int i = 0; i < r; i++) w = mm[k] ? w + 32'(ms[k][i]) : (w << 8) | 32'(ms[k][i]);
          m_r0[k] = w;
          m_v[k]  = 1'b1;
          mc[k]   = 0;
          if (en) begin
            ms[k][0] = data_in; mc[k] = 1; mm[k] = mode;
          end
        end else if (en) begin
          m_ov[k] = 1'b1;
        end
      end else if (en) begin
        if (mc[k] == 0) mm[k] = mode;
        ms[k][mc[k]] = data_in;
        mc[k] = mc[k] + 1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({r0_2, v2, f2, o2} !== 19'h0) begin
      n_err++; $display("FAIL reset_dut2 got %h want 0", {r0_2, v2, f2, o2});
    end
    n_vec++;
    if ({r0_4, v4, f4, o4} !== 35'h0) begin
      n_err++; $display("FAIL reset_dut4 got %h want 0", {r0_4, v4, f4, o4});
    end
  endtask

  task automatic test_pack2();
    do_reset();
    push(8'ha5, 1'b0, 1'b0);
    push(8'hff, 1'b0, 1'b0);
    n_vec++;
    if (f2 !== 1'b1) begin n_err++; $display("FAIL pack2_full got %b want 1", f2); end
    tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if (r0_2 !== 16'ha5ff) begin n_err++; $display("FAIL pack2_r0 got %h want a5ff", r0_2); end
    n_vec++;
    if ({v2, f2} !== 2'b10) begin
      n_err++; $display("FAIL pack2_valid_full got %b want 10", {v2, f2});
    end
    tick();
    n_vec++;
    if ({v2, r0_2} !== {1'b0, 16'ha5ff}) begin
      n_err++; $display("FAIL pack2_hold got %h want 0a5ff", {v2, r0_2});
    end
  endtask

  task automatic test_accum2();
    do_reset();
    push(8'ha5, 1'b1, 1'b0);
    push(8'hff, 1'b0, 1'b0);
    load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if (r0_2 !== 16'h01a4) begin n_err++; $display("FAIL accum2_r0 got %h want 01a4", r0_2); end
    n_vec++;
    if (v2 !== 1'b1) begin n_err++; $display("FAIL accum2_valid got %b want 1", v2); end
  endtask

  task automatic test_pack4();
    do_reset();
    load = 1'b1;
    tick();
    push(8'h11, 1'b0, 1'b1);
    push(8'h22, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b1);
    n_vec++;
    if ({v4, r0_4} !== 33'h0) begin
      n_err++; $display("FAIL pack4_fill_load got %h want 0", {v4, r0_4});
    end
    push(8'h44, 1'b0, 1'b0);
    n_vec++;
    if (f4 !== 1'b1) begin n_err++; $display("FAIL pack4_full got %b want 1", f4); end
    load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if (r0_4 !== 32'h11223344) begin
      n_err++; $display("FAIL pack4_r0 got %h want 11223344", r0_4);
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if ({v4, r0_4} !== {1'b0, 32'h11223344}) begin
      n_err++; $display("FAIL pack4_idle_load got %h want 011223344", {v4, r0_4});
    end
  endtask

  task automatic test_overrun();
    do_reset();
    push(8'ha5, 1'b0, 1'b0);
    push(8'hff, 1'b0, 1'b0);
    push(8'h77, 1'b0, 1'b0);
    n_vec++;
    if ({o2, f2} !== 2'b11) begin
      n_err++; $display("FAIL ovr_flag got %b want 11", {o2, f2});
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if (r0_2 !== 16'ha5ff) begin n_err++; $display("FAIL ovr_r0 got %h want a5ff", r0_2); end
    tick();
    n_vec++;
    if (o2 !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got %b want 1", o2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(8'ha5, 1'b0, 1'b0);
    push(8'hff, 1'b0, 1'b0);
    push(8'h12, 1'b0, 1'b1);
    n_vec++;
    if ({v2, r0_2} !== {1'b1, 16'ha5ff}) begin
      n_err++; $display("FAIL b2b_first got %h want 1a5ff", {v2, r0_2});
    end
    push(8'h34, 1'b0, 1'b0);
    load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if ({v2, r0_2, o2} !== {1'b1, 16'h1234, 1'b0}) begin
      n_err++; $display("FAIL b2b_second got %h want 1_1234_0", {v2, r0_2, o2});
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push(8'ha5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    n_vec++;
    if ({r0_2, v2, f2, o2} !== 19'h0) begin
      n_err++; $display("FAIL midrst_during got %h want 0", {r0_2, v2, f2, o2});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({r0_2, v2, f2, o2} !== 19'h0) begin
      n_err++; $display("FAIL midrst_after got %h want 0", {r0_2, v2, f2, o2});
    end
    push(8'h01, 1'b0, 1'b0);
    push(8'h02, 1'b0, 1'b0);
    load = 1'b1;
    tick();
    load = 1'b0;
    n_vec++;
    if (r0_2 !== 16'h0102) begin n_err++; $display("FAIL midrst_r0 got %h want 0102", r0_2); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst     = (c < 2) || ($urandom_range(0, 79) == 0);
      en      = ($urandom_range(0, 3) != 0);
      load    = ($urandom_range(0, 2) == 0);
      mode    = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      m_step(0, 2);
      m_step(1, 4);
      tick();
      n_vec++;
      if ({r0_2, v2, f2, o2} !== {m_r0[0][15:0], m_v[0], mc[0] == 2, m_ov[0]}) begin
        n_err++;
        $display("FAIL rand_dut2 cyc %0d got r0=%h v=%b f=%b o=%b want r0=%h v=%b f=%b o=%b",
                 c, r0_2, v2, f2, o2, m_r0[0][15:0], m_v[0], mc[0] == 2, m_ov[0]);
      end
      n_vec++;
      if ({r0_4, v4, f4, o4} !== {m_r0[1], m_v[1], mc[1] == 4, m_ov[1]}) begin
        n_err++;
        $display("FAIL rand_dut4 cyc %0d got r0=%h v=%b f=%b o=%b want r0=%h v=%b f=%b o=%b",
                 c, r0_4, v4, f4, o4, m_r0[1], m_v[1], mc[1] == 4, m_ov[1]);
      end
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_pack2();
    test_accum2();
    test_pack4();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
